// File: rtl/q3_pkg.sv
// -----------------------------------------------------------------------------
// q3_pkg
// Shared constants and types for the Q3 encoder/decoder pair. The encoder and
// the stream decoder both take their defaults from here, so the two sides can
// never disagree about the additive constant or the history seeds.
//   Q3_W        sample width in bits
//   Q3_K        additive constant applied by the encoder
//   Q3_SEED_A   seed for the two first-stage history registers
//   Q3_SEED_B   seed for the second-stage history register
//   Q3_COUNT_W  width of the decoded-beat counter
//   q3_dec_state_t  decoder priming state
// -----------------------------------------------------------------------------
package q3_pkg;

   localparam int Q3_W       = 8;
   localparam int Q3_K       = 17;
   localparam int Q3_SEED_A  = 3;
   localparam int Q3_SEED_B  = 0;
   localparam int Q3_COUNT_W = 16;

   // SEEDED: history still holds the seeds, ONE: one real sample in history,
   // STEADY: both history taps hold recovered samples.
   typedef enum logic [1:0] {
      SEEDED = 2'd0,
      ONE    = 2'd1,
      STEADY = 2'd2
   } q3_dec_state_t;

endpackage

// File: rtl/q3_stream_decoder_if.sv
// -----------------------------------------------------------------------------
// q3_stream_decoder_if
// Valid/ready stream bundle around the Q3 decoder: the encoded input stream and
// the decoded output stream.
//   in_data/in_valid/in_ready     encoded sample y[n] handshake
//   out_data/out_valid/out_ready  decoded sample x[n] handshake
// Modports:
//   master  the side that feeds y and consumes x (wrapper or testbench)
//   slave   the decoder itself
// -----------------------------------------------------------------------------
interface q3_stream_decoder_if
   import q3_pkg::*;
#(
   parameter int W = Q3_W
);

   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

endinterface

// File: rtl/q3_dec_history.sv
// -----------------------------------------------------------------------------
// q3_dec_history
// The decoder's private copy of the encoder history registers.
//   clk, reset_n  clock and asynchronous active-low reset
//   clear         synchronous stream restart, reloads the seeds
//   advance       a beat was accepted, shift new_x into the history
//   new_x         the sample just recovered
//   h1            mirror of encoder reg1, x[n-1]
//   h3            mirror of encoder reg3, x[n-2]
// -----------------------------------------------------------------------------
module q3_dec_history
   import q3_pkg::*;
#(
   parameter int W      = Q3_W,
   parameter int SEED_A = Q3_SEED_A,
   parameter int SEED_B = Q3_SEED_B
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         advance,
   input  logic [W-1:0] new_x,
   output logic [W-1:0] h1,
   output logic [W-1:0] h3
);

   localparam logic [W-1:0] SEED_A_W = SEED_A[W-1:0];
   localparam logic [W-1:0] SEED_B_W = SEED_B[W-1:0];

   logic [W-1:0] h2;

   // h2 mirrors the encoder's reg2 so that h3 picks up the seed of the first
   // stage on the second beat after a restart, exactly like the encoder does.
   // Reset and clear both reload the seeds; clear wins over a new beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h1 <= SEED_A_W;
         h2 <= SEED_A_W;
         h3 <= SEED_B_W;
      end else if (clear) begin
         h1 <= SEED_A_W;
         h2 <= SEED_A_W;
         h3 <= SEED_B_W;
      end else if (advance) begin
         h3 <= h2;
         h1 <= new_x;
         h2 <= new_x;
      end
   end

endmodule

// File: rtl/q3_stream_decoder.sv
// -----------------------------------------------------------------------------
// q3_stream_decoder
// Inverse of the Q3 encoder y[n] = x[n-2] ^ x[n-1] ^ (x[n] + K). Recovers x[n]
// from the encoded stream through a one-entry output register.
//   clk, reset_n  clock and asynchronous active-low reset (also clears out_data)
//   clear         synchronous stream restart, drops any beat offered with it
//   bus           slave side of the y/x valid/ready streams
//   primed        both history taps hold recovered samples
//   count         decoded beats since clear/reset, saturating
// -----------------------------------------------------------------------------
module q3_stream_decoder
   import q3_pkg::*;
#(
   parameter int W      = Q3_W,
   parameter int K      = Q3_K,
   parameter int SEED_A = Q3_SEED_A,
   parameter int SEED_B = Q3_SEED_B
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   q3_stream_decoder_if.slave    bus,
   output logic                  primed,
   output logic [Q3_COUNT_W-1:0] count
);

   localparam logic [W-1:0]          K_W     = K[W-1:0];
   localparam logic [Q3_COUNT_W-1:0] CNT_MAX = {Q3_COUNT_W{1'b1}};

   logic          accept;
   logic          retire;
   logic [W-1:0]  h1;
   logic [W-1:0]  h3;
   logic [W-1:0]  dec_x;
   q3_dec_state_t state;

   // One-entry output register: a new beat fits when the slot is empty or is
   // being emptied this cycle. A beat offered together with clear is refused.
   assign bus.in_ready = !clear && (!bus.out_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign retire       = bus.out_valid && bus.out_ready;

   // Undo the XOR with both history taps, then the add; the borrow falls off
   // the top so the result wraps modulo 2^W like the encoder's sum did.
   assign dec_x = (bus.in_data ^ h1 ^ h3) - K_W;

   q3_dec_history #(
      .W      (W),
      .SEED_A (SEED_A),
      .SEED_B (SEED_B)
   ) u_history (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .advance (accept),
      .new_x   (dec_x),
      .h1      (h1),
      .h3      (h3)
   );

   // Output slot. clear only invalidates the slot; out_data keeps its last
   // value so nothing downstream sees a spurious change. Loading a new beat
   // takes priority over retiring the old one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
      end else if (clear) begin
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_data  <= dec_x;
         bus.out_valid <= 1'b1;
      end else if (retire) begin
         bus.out_valid <= 1'b0;
      end
   end

   // Priming FSM, advanced once per accepted beat. primed is registered
   // alongside the state so it always equals (state == STEADY).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= SEEDED;
         primed <= 1'b0;
      end else if (clear) begin
         state  <= SEEDED;
         primed <= 1'b0;
      end else if (accept) begin
         case (state)
            SEEDED: begin
               state  <= ONE;
               primed <= 1'b0;
            end
            ONE: begin
               state  <= STEADY;
               primed <= 1'b1;
            end
            default: begin
               state  <= STEADY;
               primed <= 1'b1;
            end
         endcase
      end
   end

   // Decoded-beat counter; it parks at all-ones while decoding carries on.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (accept && (count != CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule
